// File: rtl/ssd1306_pkg.sv
// Shared opcodes, addressing-mode encodings and argument-state enum for the
// SSD1306 SPI sink.
package ssd1306_pkg;

  localparam logic [7:0] CMD_SET_MODE    = 8'h20;
  localparam logic [7:0] CMD_COL_RANGE   = 8'h21;
  localparam logic [7:0] CMD_PAGE_RANGE  = 8'h22;
  localparam logic [7:0] CMD_CONTRAST    = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] CMD_SEG_NORM    = 8'hA0;
  localparam logic [7:0] CMD_SEG_REMAP   = 8'hA1;
  localparam logic [7:0] CMD_INV_OFF     = 8'hA6;
  localparam logic [7:0] CMD_INV_ON      = 8'hA7;
  localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
  localparam logic [7:0] CMD_COM_NORM    = 8'hC0;
  localparam logic [7:0] CMD_COM_REMAP   = 8'hC8;
  localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
  localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
  localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
  localparam logic [7:0] CMD_VCOMH       = 8'hDB;

  localparam logic [1:0] AM_HORZ = 2'd0;
  localparam logic [1:0] AM_VERT = 2'd1;
  localparam logic [1:0] AM_PAGE = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ARG_MODE,
    ARG_CONTRAST,
    COL_S,
    COL_E,
    PAGE_S,
    PAGE_E,
    ARG_SKIP
  } arg_state_t;

  // Commands whose single argument byte is accepted but has no effect here.
  function automatic logic is_skip_cmd(input logic [7:0] op);
    return op inside {CMD_MUX_RATIO, CMD_DISP_OFFSET, CMD_CLK_DIV, CMD_PRECHARGE,
                      CMD_COM_PINS, CMD_VCOMH, CMD_CHARGE_PUMP};
  endfunction

endpackage

// File: rtl/ssd1306_spi_sink_rx.sv
// SPI mode-0 byte receiver: synchronises the async pins, detects scl rises and
// assembles MSB-first bytes, flagging each with the dc level seen at bit 8.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       scl,
  input  logic       mosi,
  input  logic       dc,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       rx_dc
);

  logic [SYNC_STAGES-1:0] ss_pipe_reg;
  logic [SYNC_STAGES-1:0] scl_pipe_reg;
  logic [SYNC_STAGES-1:0] mosi_pipe_reg;
  logic [SYNC_STAGES-1:0] dc_pipe_reg;

  logic       scl_prev_reg;
  logic       scl_rise_reg;
  logic       mosi_d_reg;
  logic       dc_d_reg;
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic       last_reg;
  logic       dc_hold_reg;

  logic ss_sync, scl_sync, mosi_sync, dc_sync;
  assign ss_sync   = ss_pipe_reg[SYNC_STAGES-1];
  assign scl_sync  = scl_pipe_reg[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe_reg[SYNC_STAGES-1];
  assign dc_sync   = dc_pipe_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      ss_pipe_reg   <= '1;
      scl_pipe_reg  <= '0;
      mosi_pipe_reg <= '0;
      dc_pipe_reg   <= '0;
      scl_prev_reg  <= 1'b0;
      scl_rise_reg  <= 1'b0;
      mosi_d_reg    <= 1'b0;
      dc_d_reg      <= 1'b0;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'd0;
      last_reg      <= 1'b0;
      dc_hold_reg   <= 1'b0;
      byte_valid    <= 1'b0;
      rx_byte       <= 8'd0;
      rx_dc         <= 1'b0;
    end else begin
      ss_pipe_reg   <= {ss_pipe_reg[SYNC_STAGES-2:0], ss};
      scl_pipe_reg  <= {scl_pipe_reg[SYNC_STAGES-2:0], scl};
      mosi_pipe_reg <= {mosi_pipe_reg[SYNC_STAGES-2:0], mosi};
      dc_pipe_reg   <= {dc_pipe_reg[SYNC_STAGES-2:0], dc};

      // mosi/dc are delayed alongside the edge flag so they stay aligned with it.
      scl_prev_reg <= scl_sync;
      scl_rise_reg <= scl_sync & ~scl_prev_reg;
      mosi_d_reg   <= mosi_sync;
      dc_d_reg     <= dc_sync;

      last_reg   <= 1'b0;
      byte_valid <= last_reg;
      if (last_reg) begin
        rx_byte <= shift_reg;
        rx_dc   <= dc_hold_reg;
      end

      if (ss_sync) begin
        bit_cnt_reg <= 3'd0;
      end else if (scl_rise_reg) begin
        shift_reg   <= {shift_reg[6:0], mosi_d_reg};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          last_reg    <= 1'b1;
          dc_hold_reg <= dc_d_reg;
        end
      end
    end
  end

endmodule

// File: rtl/ssd1306_spi_sink.sv
// SSD1306-class controller front end: decodes the SPI command/data stream,
// tracks display state and turns each data byte into one framebuffer write.
module ssd1306_spi_sink
  import ssd1306_pkg::*;
#(
  parameter int X_SIZE      = 128,
  parameter int Y_SIZE      = 64,
  parameter int SYNC_STAGES = 2,
  parameter int FB_ADDR_W   = (X_SIZE * (Y_SIZE / 8) > 1) ? $clog2(X_SIZE * (Y_SIZE / 8)) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ss,
  input  logic                 scl,
  input  logic                 mosi,
  input  logic                 dc,
  output logic                 fb_wr,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [7:0]           fb_data,
  output logic                 display_on,
  output logic                 invert,
  output logic [7:0]           contrast,
  output logic                 seg_remap,
  output logic                 com_remap,
  output logic [1:0]           addr_mode
);

  localparam int         PAGES    = Y_SIZE / 8;
  localparam logic [7:0] COL_MAX  = 8'(X_SIZE - 1);
  localparam logic [2:0] PAGE_MAX = 3'(PAGES - 1);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rx_dc;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ss         (ss),
    .scl        (scl),
    .mosi       (mosi),
    .dc         (dc),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .rx_dc      (rx_dc)
  );

  arg_state_t state_reg;
  logic [7:0] col_reg, col_start_reg, col_end_reg;
  logic [2:0] page_reg, page_start_reg, page_end_reg;

  function automatic logic [7:0] clamp_col(input logic [7:0] v);
    return (v > COL_MAX) ? COL_MAX : v;
  endfunction

  function automatic logic [2:0] clamp_page(input logic [7:0] v);
    return (v > {5'd0, PAGE_MAX}) ? PAGE_MAX : v[2:0];
  endfunction

  logic [7:0] col_step, col_next;
  logic [2:0] page_step, page_next;
  logic       col_at_end, page_at_end;

  // >= rather than == so a window with start > end still wraps.
  always_comb begin
    col_at_end  = (col_reg >= col_end_reg);
    page_at_end = (page_reg >= page_end_reg);
    col_step    = col_at_end ? col_start_reg : col_reg + 8'd1;
    page_step   = page_at_end ? page_start_reg : page_reg + 3'd1;
    col_next    = col_reg;
    page_next   = page_reg;
    case (addr_mode)
      AM_HORZ: begin
        col_next = col_step;
        if (col_at_end) page_next = page_step;
      end
      AM_VERT: begin
        page_next = page_step;
        if (page_at_end) col_next = col_step;
      end
      default: col_next = col_step;
    endcase
  end

  logic [FB_ADDR_W-1:0] lin_addr;
  assign lin_addr = FB_ADDR_W'(int'(page_reg) * X_SIZE + int'(col_reg));

  always_ff @(posedge clk) begin
    if (!rst) begin
      fb_wr          <= 1'b0;
      fb_addr        <= '0;
      fb_data        <= 8'd0;
      display_on     <= 1'b0;
      invert         <= 1'b0;
      contrast       <= 8'h7F;
      seg_remap      <= 1'b0;
      com_remap      <= 1'b0;
      addr_mode      <= AM_PAGE;
      state_reg      <= IDLE;
      col_reg        <= 8'd0;
      page_reg       <= 3'd0;
      col_start_reg  <= 8'd0;
      col_end_reg    <= COL_MAX;
      page_start_reg <= 3'd0;
      page_end_reg   <= PAGE_MAX;
    end else begin
      fb_wr <= 1'b0;
      if (byte_valid) begin
        if (rx_dc) begin
          // Data always lands in the framebuffer, even mid-argument.
          fb_wr     <= 1'b1;
          fb_addr   <= lin_addr;
          fb_data   <= rx_byte;
          col_reg   <= col_next;
          page_reg  <= page_next;
          state_reg <= IDLE;
        end else begin
          state_reg <= IDLE;
          case (state_reg)
            ARG_MODE: begin
              if (rx_byte[1:0] != 2'd3) addr_mode <= rx_byte[1:0];
            end
            ARG_CONTRAST: contrast <= rx_byte;
            COL_S: begin
              col_start_reg <= clamp_col(rx_byte);
              state_reg     <= COL_E;
            end
            COL_E: begin
              col_end_reg <= clamp_col(rx_byte);
              col_reg     <= col_start_reg;
            end
            PAGE_S: begin
              page_start_reg <= clamp_page(rx_byte);
              state_reg      <= PAGE_E;
            end
            PAGE_E: begin
              page_end_reg <= clamp_page(rx_byte);
              page_reg     <= page_start_reg;
            end
            ARG_SKIP: ;
            default: begin
              if (rx_byte[7:4] == 4'h0) begin
                if (addr_mode == AM_PAGE) col_reg <= clamp_col({col_reg[7:4], rx_byte[3:0]});
              end else if (rx_byte[7:4] == 4'h1) begin
                if (addr_mode == AM_PAGE) col_reg <= clamp_col({rx_byte[3:0], col_reg[3:0]});
              end else if (rx_byte[7:3] == 5'b10110) begin
                if (addr_mode == AM_PAGE) page_reg <= clamp_page({5'd0, rx_byte[2:0]});
              end else begin
                case (rx_byte)
                  CMD_SET_MODE:   state_reg  <= ARG_MODE;
                  CMD_CONTRAST:   state_reg  <= ARG_CONTRAST;
                  CMD_COL_RANGE:  state_reg  <= COL_S;
                  CMD_PAGE_RANGE: state_reg  <= PAGE_S;
                  CMD_DISP_ON:    display_on <= 1'b1;
                  CMD_DISP_OFF:   display_on <= 1'b0;
                  CMD_INV_ON:     invert     <= 1'b1;
                  CMD_INV_OFF:    invert     <= 1'b0;
                  CMD_SEG_NORM:   seg_remap  <= 1'b0;
                  CMD_SEG_REMAP:  seg_remap  <= 1'b1;
                  CMD_COM_NORM:   com_remap  <= 1'b0;
                  CMD_COM_REMAP:  com_remap  <= 1'b1;
                  default: begin
                    if (is_skip_cmd(rx_byte)) state_reg <= ARG_SKIP;
                  end
                endcase
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/ssd1306_spi_sink.md
Name: ssd1306_spi_sink

Overview:
- Parametrised SPI-slave front end for the emulated SSD1306-class OLED.
- Decodes the command/data byte stream from the MCU core's SPI and OledDC/OledCS pins.
- Tracks controller state: addressing mode, column/page windows, display on, invert, contrast and remap flags.
- Emits one framebuffer write per data byte to an external VRAM port, for any X_SIZE×Y_SIZE panel and all three addressing modes.

Parameters:
X_SIZE, 128, panel columns (1..256)
Y_SIZE, 64, panel rows; multiple of 8; PAGES = Y_SIZE/8 (1..8)
SYNC_STAGES, 2, flip-flop synchroniser depth on ss/scl/mosi/dc (>=2)
FB_ADDR_W, clog2(X_SIZE*PAGES), framebuffer address width

Ports:
clk  in  1  single system clock; must be >= 4x the scl frequency
rst  in  1  synchronous, active-low reset
ss  in  1  chip select, active low, asynchronous
scl  in  1  SPI clock, mode 0, asynchronous
mosi  in  1  SPI data, MSB first
dc  in  1  0 = command byte, 1 = data byte; sampled with the 8th bit
fb_wr  out  1  one-cycle framebuffer write strobe
fb_addr  out  FB_ADDR_W  page*X_SIZE + column
fb_data  out  8  data byte; bit0 is the top row of the page
display_on  out  1  set by 0xAF, cleared by 0xAE
invert  out  1  set by 0xA7, cleared by 0xA6
contrast  out  8  argument of 0x81
seg_remap  out  1  0xA0 -> 0, 0xA1 -> 1
com_remap  out  1  0xC0 -> 0, 0xC8 -> 1
addr_mode  out  2  0 = horizontal, 1 = vertical, 2 = page

Behaviour:
- Reset (rst==0 at a clk edge) sets:
  - fb_wr=0, fb_addr=0, fb_data=0
  - display_on=0, invert=0, contrast=8'h7F, seg_remap=0, com_remap=0, addr_mode=2
  - col=0, page=0, col window 0..X_SIZE-1, page window 0..PAGES-1
  - bit counter 0, argument state IDLE
- Reset overrides everything, including a byte in flight.
- Receiver:
  - Inputs pass through SYNC_STAGES FFs.
  - A registered scl rising edge with ss_sync==0 shifts in mosi.
  - On the 8th bit, byte and dc are latched and a byte_valid pulse is issued.
  - ss_sync high clears the bit counter; partial bits are discarded; argument state is kept.
- Latency:
  - fb_wr rises exactly SYNC_STAGES+3 clk cycles after the clk edge that first samples the 8th scl rise.
  - Register updates take effect at the same point.
- Argument FSM:
  - States: IDLE, ARG_MODE, ARG_CONTRAST, COL_S, COL_E, PAGE_S, PAGE_E, ARG_SKIP.
  - 0x20 -> ARG_MODE. Argument[1:0] is written to addr_mode; value 3 is ignored.
  - 0x81 -> ARG_CONTRAST.
  - 0x21 -> COL_S -> COL_E. Sets the col window and loads col = start.
  - 0x22 -> PAGE_S -> PAGE_E. Sets the page window and loads page = start.
  - 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0x8D -> ARG_SKIP; the next byte is consumed and ignored.
  - All other commands are single-byte:
    - 0x00-0x0F sets col[3:0]; 0x10-0x1F sets col[7:4]. Both apply in page mode only.
    - 0xB0-0xB7 sets page, in page mode only.
    - Unknown opcodes are ignored.
  - A data byte (dc=1) arriving in a non-IDLE state aborts to IDLE and is written normally.
- Argument clamping:
  - Column arguments above X_SIZE-1 clamp to X_SIZE-1.
  - Page arguments above PAGES-1 clamp to PAGES-1.
  - Page-mode nibble writes clamp the same way.
- Data byte: fb_wr=1 with fb_addr={page,col} linear and fb_data=byte, then the pointer advances.
- Pointer advance, horizontal mode:
  - If col>=col_end: col=col_start, then page steps (page>=page_end ? page_start : page+1).
  - Otherwise col+1.
- Pointer advance, vertical mode:
  - If page>=page_end: page=page_start, then col steps (col>=col_end ? col_start : col+1).
  - Otherwise page+1.
- Pointer advance, page mode: col>=col_end ? col_start : col+1; page is unchanged.
- The >= compare also guarantees wrap when start > end.
- fb_wr is never asserted in two consecutive cycles; byte rate is bounded by the clk/scl ratio.

Decomposition:
- Package ssd1306_pkg holds:
  - opcode constants (CMD_DISP_ON, CMD_SET_MODE, CMD_COL_RANGE, ...)
  - addr_mode encodings (AM_HORZ, AM_VERT, AM_PAGE)
  - the FSM state enum
- One sub-module, spi_byte_rx: synchronisers, edge detect, shift register, bit counter, byte_valid/dc out.
- Decoder, FSM and pointer logic live in the parent.

Test Plan:
- Reset, then mode 0: cmd 21 00 7F, cmd 22 00 07, then 1024 data bytes. Required: fb_addr runs 0..1023 with no gaps and wraps to 0 on byte 1025.
- Vertical mode: cmd 20 01, window col 2..3, page 1..2, data AA BB CC DD EE. Required: addresses 130, 258, 131, 259, 130.
- Page mode: cmd B3 05 12 (page 3, col 0x25), 3 data bytes. Required: addresses 421, 422, 423. Then col=0x7F plus 2 data bytes: addresses 511, 384.
- Cmd AF A7 81 40 A1 C8, then cmd 8D 14. Required: display_on=1, invert=1, contrast=0x40, seg_remap=1, com_remap=1, and 0x14 decoded as nothing.
- ss deasserted after 5 bits of a data byte, then a full byte 0x3C. Required: exactly one fb_wr with data 0x3C. Cmd 81 followed by a data byte 0x55: contrast unchanged, 0x55 written.
- rst pulsed low mid-byte and mid-argument. Required: all outputs return to reset values on the next clk edge, and the next full byte decodes as a fresh command.
